mcu_cmd_scheduler: RTL

Shares the single 3-wire open-drain MCU command link (MCU_EN / MCU_DATA / MCU_CLOCK) among several on-chip requesters, such as PTT control, IP reporting, firmware/logo display and status. The block arbitrates pending 9-byte command frames and serialises the granted frame MSB-first. It enforces the power-up delay and the inter-frame gap the MCU needs. It sits beside the bootloader/application top level on the 80 kHz control clock.

---
 rtl/mcu_link_pkg.sv | 28 ++
 rtl/mcu_frame_tx.sv | 73 +++++++
 rtl/mcu_cmd_scheduler.sv | 116 +++++++++++
 3 files changed

// File: rtl/mcu_link_pkg.sv
// Shared definitions for the MCU command link: scheduler states, serializer
// phases, frame width and MCU command codes.
`timescale 1ns/1ps
package mcu_link_pkg;

   localparam int FRAME_BITS = 72;

   localparam logic [7:0] CMD_FIRMWARE   = 8'h01;
   localparam logic [7:0] CMD_LOGO       = 8'h02;
   localparam logic [7:0] CMD_IP         = 8'h03;
   localparam logic [7:0] CMD_BOOTLOADER = 8'h04;
   localparam logic [7:0] CMD_PTT_ON     = 8'h05;
   localparam logic [7:0] CMD_PTT_OFF    = 8'h06;

   typedef enum logic [1:0] {
      ST_STARTUP,
      ST_IDLE,
      ST_SEND,
      ST_GAP
   } sched_state_e;

   typedef enum logic [1:0] {
      PH_DATA,
      PH_LOW,
      PH_HIGH
   } tx_phase_e;

endpackage

// File: rtl/mcu_frame_tx.sv
// Serializes one 72-bit frame MSB-first onto the open-drain EN/DATA/CLOCK
// pads: one EN setup cycle, then data / clock-low / clock-high per bit.
`timescale 1ns/1ps
module mcu_frame_tx
   import mcu_link_pkg::*;
#(
   parameter int CLK_DIV = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [FRAME_BITS-1:0] frame_in,
   output logic                  done,
   inout  wire                   MCU_EN,
   inout  wire                   MCU_DATA,
   inout  wire                   MCU_CLOCK
);

   logic                  active;
   logic                  setup;
   logic [FRAME_BITS-1:0] shreg;
   logic [6:0]            bit_cnt;
   logic [15:0]           div_cnt;
   tx_phase_e             phase;
   logic                  phase_end;

   assign phase_end = (div_cnt == 16'(CLK_DIV - 1));
   // done marks the last EN-low cycle; the lines release on the following edge
   assign done = active && !setup && (phase == PH_HIGH) && phase_end &&
                 (bit_cnt == 7'(FRAME_BITS - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         active  <= 1'b0;
         setup   <= 1'b0;
         shreg   <= '0;
         bit_cnt <= '0;
         div_cnt <= '0;
         phase   <= PH_DATA;
      end else if (!active) begin
         if (start) begin
            active  <= 1'b1;
            setup   <= 1'b1;
            shreg   <= frame_in;
            bit_cnt <= '0;
            div_cnt <= '0;
            phase   <= PH_DATA;
         end
      end else if (setup) begin
         setup <= 1'b0;
      end else if (!phase_end) begin
         div_cnt <= div_cnt + 16'd1;
      end else begin
         div_cnt <= '0;
         case (phase)
            PH_DATA: phase <= PH_LOW;
            PH_LOW:  phase <= PH_HIGH;
            default: begin
               phase   <= PH_DATA;
               shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
               bit_cnt <= bit_cnt + 7'd1;
               if (done) active <= 1'b0;
            end
         endcase
      end
   end

   // Data is held for all three phases of a bit, so it is stable while CLOCK is low
   assign MCU_EN    = active ? 1'b0 : 1'bz;
   assign MCU_DATA  = (active && !setup && !shreg[FRAME_BITS-1]) ? 1'b0 : 1'bz;
   assign MCU_CLOCK = (active && !setup && (phase == PH_LOW)) ? 1'b0 : 1'bz;

endmodule

// File: rtl/mcu_cmd_scheduler.sv
// Round-robin scheduler sharing the MCU command link among N_REQ requesters.
// Define MCU_PTT_PRIORITY_EN to give requester 0 (PTT) strict priority and a short gap.
`timescale 1ns/1ps
module mcu_cmd_scheduler
   import mcu_link_pkg::*;
#(
   parameter  int N_REQ          = 4,
   parameter  int CLK_DIV        = 1,
   parameter  int STARTUP_CYCLES = 4000,
   parameter  int GAP_CYCLES     = 4000,
   localparam int IW             = $clog2(N_REQ)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ*FRAME_BITS-1:0] frame,
   output logic [N_REQ-1:0]            ack,
   output logic                        busy,
   output logic [IW-1:0]               grant_idx,
   output logic [15:0]                 frame_cnt,
   inout  wire                         MCU_EN,
   inout  wire                         MCU_DATA,
   inout  wire                         MCU_CLOCK
);

   sched_state_e          state, state_nx;
   logic [31:0]           cnt;
   logic [31:0]           gap_last;
   logic [31:0]           gap_next;
   logic [IW-1:0]         rr_last;
   logic [IW-1:0]         rr_sel;
   logic [IW-1:0]         sel;
   logic                  ptt_win;
   logic                  grant;
   logic                  tx_done;
   logic [FRAME_BITS-1:0] tx_frame;

   // Nearest pending requester after rr_last wins; scan far-to-near so the last hit is closest
   always_comb begin
      rr_sel = rr_last;
      for (int k = N_REQ; k >= 1; k--) begin
         if (req[(int'(rr_last) + k) % N_REQ])
            rr_sel = IW'((int'(rr_last) + k) % N_REQ);
      end
   end

`ifdef MCU_PTT_PRIORITY_EN
   assign ptt_win  = req[0];
   assign gap_next = req[0] ? 32'(GAP_CYCLES / 8 - 2) : 32'(GAP_CYCLES - 2);
`else
   assign ptt_win  = 1'b0;
   assign gap_next = 32'(GAP_CYCLES - 2);
`endif

   assign sel  = ptt_win ? '0 : rr_sel;
   assign busy = (state == ST_SEND) || (state == ST_GAP);

   // GAP is timed from the edge that releases the lines, hence the -2 terminal count
   always_comb begin
      state_nx = state;
      grant    = 1'b0;
      case (state)
         ST_STARTUP: if (cnt == 32'(STARTUP_CYCLES - 1)) state_nx = ST_IDLE;
         ST_IDLE: begin
            if (|req) begin
               grant    = 1'b1;
               state_nx = ST_SEND;
            end
         end
         ST_SEND:    if (tx_done) state_nx = ST_GAP;
         ST_GAP:     if (cnt == gap_last) state_nx = ST_IDLE;
         default:    state_nx = ST_STARTUP;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_STARTUP;
         cnt       <= '0;
         gap_last  <= 32'(GAP_CYCLES - 2);
         ack       <= '0;
         grant_idx <= IW'(N_REQ - 1);
         rr_last   <= IW'(N_REQ - 1);
         frame_cnt <= '0;
      end else begin
         state <= state_nx;
         cnt   <= (state_nx != state) ? '0 : cnt + 32'd1;
         ack   <= grant ? (N_REQ'(1) << sel) : '0;
         if (grant) begin
            grant_idx <= sel;
            if (!ptt_win) rr_last <= sel;
         end
         if (tx_done) begin
            frame_cnt <= frame_cnt + 16'd1;
            gap_last  <= gap_next;
         end
      end
   end

   // The frame is captured by the serializer at the end of the ack cycle
   assign tx_frame = frame[int'(grant_idx)*FRAME_BITS +: FRAME_BITS];

   mcu_frame_tx #(
      .CLK_DIV(CLK_DIV)
   ) u_tx (
      .clock    (clock),
      .reset    (reset),
      .start    (|ack),
      .frame_in (tx_frame),
      .done     (tx_done),
      .MCU_EN   (MCU_EN),
      .MCU_DATA (MCU_DATA),
      .MCU_CLOCK(MCU_CLOCK)
   );

endmodule
